skip_ctl: RTL and testbench
===========================

// Module: skip_ctl
// PURPOSE
//  Sequencer that safely (re)programs a LEN-bit clock-skip ring (seed/mask/enable).
//  Accepts one configuration request at a time, drains the ring's enable, loads seed and mask
//  with a 2-cycle reset pulse, re-arms, then acknowledges the requester.
//  Sits between the CPU-side clock-speed register and the skip ring's iSEL/iMASK/iRST/iE inputs.
// PARAMETERS
//  LEN     16      ring width; width of seed and mask buses
//  DEFSEL  16'h1   seed loaded after reset (must be non-zero)
//  DEFMASK 16'h0   mask loaded after reset
//  DEFE    1'b0    ring enable applied after reset
//  TMO     64      watchdog limit in cycles per wait state (SKIP_CTL_TIMEOUT_EN only)
// PORTS
//  iCLK    in   1    clock; all logic posedge
//  iRST_N  in   1    synchronous active-low reset
//  iREQ    in   1    config request (level); sampled only in IDLE
//  iSEL    in   LEN  requested seed
//  iMASK   in   LEN  requested skip mask
//  iEN     in   1    requested ring enable
//  oACK    out  1    1-cycle pulse: request applied
//  oBUSY   out  1    high in every state except IDLE
//  oERR    out  1    sticky watchdog error
//  oSEL    out  LEN  to ring iSEL
//  oMASK   out  LEN  to ring iMASK
//  oRST    out  1    to ring iRST (active high load)
//  oE      out  1    to ring iE
//  iST     in   1    ring oST (applied enable status)
// BEHAVIOUR
//  - Reset (iRST_N=0 at posedge): state=INIT, oE=0, oRST=0, oACK=0, oERR=0, oSEL=DEFSEL,
//    oMASK=DEFMASK, staged en=DEFE. Reset mid-operation aborts; no oACK for aborted request.
//  - INIT: internal request with DEFSEL/DEFMASK/DEFE -> DRAIN; its completion gives no oACK.
//  - IDLE: oBUSY=0. iREQ=1 -> capture iSEL/iMASK/iEN into oSEL/oMASK/staged en, oE<=0, ->DRAIN.
//    iSEL==0 is replaced by 1 (ring must hold exactly the seed bits given, never empty).
//  - DRAIN: oE=0; wait iST==0 (at least 1 cycle spent here) -> LOAD.
//  - LOAD: oRST=1 for exactly 2 cycles (ring samples on posedge, applies on negedge) -> ARM.
//  - ARM: oRST=0, oE=staged en; wait iST==staged en -> DONE. Staged en 0 passes on first cycle.
//  - DONE: oACK=1 one cycle (suppressed for INIT pass) -> IDLE.
//  - Requester must drop iREQ the cycle after oACK; iREQ still high in IDLE starts a new request.
//  - iREQ while oBUSY=1 is ignored (not queued); iSEL/iMASK/iEN don't-care outside IDLE.
//  - oSEL/oMASK stable from capture until next capture; oRST never high while oE=1.
//  - Minimum request-to-oACK latency: 1 (IDLE) + 1 (DRAIN) + 2 (LOAD) + 1 (ARM) + 1 = 6 cycles
//    when iST already matches.
// CONFIGURATION
//  SKIP_CTL_TIMEOUT_EN defined: cycle counter (clog2(TMO+1) bits) cleared on entry to DRAIN and
//    ARM; reaching TMO in either -> ERR: oE=0, oRST=0, oERR=1, oBUSY=1, no oACK; leaves ERR
//    only via iRST_N. oERR clears only on reset.
//  Not defined: DRAIN/ARM wait indefinitely; oERR tied 0; no counter logic.
// TESTING
//  1 Reset 3 cycles, iST model = oE delayed 2 -> oRST high 2 cycles, oSEL=16'h1, oMASK=0,
//    oE=0, oBUSY falls, no oACK.
//  2 IDLE, iREQ=1 iSEL=16'h1 iMASK=16'h00FF iEN=1 -> oE drops, oRST 2 cycles, oE=1,
//    oACK one cycle once iST=1; oMASK=16'h00FF held.
//  3 Second iREQ (iMASK=16'hFFFF) pulsed mid-transfer -> ignored; oMASK stays 16'h00FF, one oACK.
//  4 iREQ iSEL=0 iMASK=16'h0F0F iEN=0 -> oSEL=16'h1, oE stays 0, oACK 6 cycles after request.
//  5 Assert iRST_N=0 during LOAD -> no oACK, INIT sequence reloads DEFSEL/DEFMASK.
//  6 (SKIP_CTL_TIMEOUT_EN) iST stuck 1, request -> oERR=1 after 64 DRAIN cycles, oE=0,
//    oBUSY=1 until reset; without macro bench checks oBUSY stays 1, oERR=0.

Source files
------------

// File: rtl/skip_ctl.sv
// skip_ctl -- sequencer that (re)programs a LEN-bit clock-skip ring.
//
// Takes one configuration request at a time from the CPU-side clock-speed
// register. For each request it:
//   1. drains the ring enable,
//   2. loads seed and mask with a 2-cycle load pulse,
//   3. re-arms the enable,
//   4. acknowledges the requester.
// After reset an internal request applies DEFSEL/DEFMASK/DEFE. That pass is
// not acknowledged.
//
// Ports
//   iCLK    in   1    clock, all logic on posedge
//   iRST_N  in   1    synchronous active-low reset
//   iREQ    in   1    config request (level), sampled only in IDLE
//   iSEL    in   LEN  requested seed (0 is replaced by 1)
//   iMASK   in   LEN  requested skip mask
//   iEN     in   1    requested ring enable
//   oACK    out  1    1-cycle pulse: request applied
//   oBUSY   out  1    high in every state except IDLE
//   oERR    out  1    sticky watchdog error
//   oSEL    out  LEN  to ring iSEL
//   oMASK   out  LEN  to ring iMASK
//   oRST    out  1    to ring iRST (active-high load)
//   oE      out  1    to ring iE
//   iST     in   1    ring oST (applied enable status)
//
// Optional feature: define SKIP_CTL_TIMEOUT_EN to add a per-wait-state
// watchdog of TMO cycles. On expiry the sequencer parks in ERR until reset.
module skip_ctl #(
  parameter int unsigned    LEN     = 16,
  parameter logic [LEN-1:0] DEFSEL  = {{(LEN-1){1'b0}}, 1'b1},
  parameter logic [LEN-1:0] DEFMASK = '0,
  parameter logic           DEFE    = 1'b0,
  parameter int unsigned    TMO     = 64
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  input  logic           iREQ,
  input  logic [LEN-1:0] iSEL,
  input  logic [LEN-1:0] iMASK,
  input  logic           iEN,
  output logic           oACK,
  output logic           oBUSY,
  output logic           oERR,
  output logic [LEN-1:0] oSEL,
  output logic [LEN-1:0] oMASK,
  output logic           oRST,
  output logic           oE,
  input  logic           iST
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_ARM,
    S_DONE,
    S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [LEN-1:0] sel_q, sel_d;
  logic [LEN-1:0] mask_q, mask_d;
  logic           en_q, en_d;     // staged ring enable, applied in ARM
  logic           e_q, e_d;       // ring enable as driven
  logic           init_q, init_d; // current pass is the post-reset one
  logic           ld_q, ld_d;     // second LOAD cycle

`ifdef SKIP_CTL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  // The counter is 0 in the first wait cycle, so the TMO-th cycle expires.
  assign tmo_hit = (cnt_q == CW'(TMO - 1));
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= S_INIT;
      sel_q   <= DEFSEL;
      mask_q  <= DEFMASK;
      en_q    <= DEFE;
      e_q     <= 1'b0;
      init_q  <= 1'b1;
      ld_q    <= 1'b0;
`ifdef SKIP_CTL_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      e_q     <= e_d;
      init_q  <= init_d;
      ld_q    <= ld_d;
`ifdef SKIP_CTL_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    en_d    = en_q;
    e_d     = e_q;
    init_d  = init_q;
    ld_d    = ld_q;
`ifdef SKIP_CTL_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_INIT: begin
        // Seed, mask and staged enable already hold the defaults from reset.
        e_d     = 1'b0;
        state_d = S_DRAIN;
`ifdef SKIP_CTL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_IDLE: begin
        if (iREQ) begin
          // An empty seed would stop the ring, so 0 is replaced by 1.
          sel_d   = (iSEL == '0) ? {{(LEN-1){1'b0}}, 1'b1} : iSEL;
          mask_d  = iMASK;
          en_d    = iEN;
          e_d     = 1'b0;
          state_d = S_DRAIN;
`ifdef SKIP_CTL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_DRAIN: begin
        e_d = 1'b0;
        if (!iST) begin
          ld_d    = 1'b0;
          state_d = S_LOAD;
        end
`ifdef SKIP_CTL_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      S_LOAD: begin
        // The enable is registered, so it is driven on the same edge that
        // ends LOAD. oRST and oE therefore never overlap.
        if (ld_q) begin
          e_d     = en_q;
          state_d = S_ARM;
`ifdef SKIP_CTL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          ld_d    = 1'b1;
        end
      end
      S_ARM: begin
        if (iST == en_q) begin
          state_d = S_DONE;
        end
`ifdef SKIP_CTL_TIMEOUT_EN
        else if (tmo_hit) begin
          e_d     = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        init_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        e_d = 1'b0;
      end
      default: begin
        e_d     = 1'b0;
        state_d = S_INIT;
      end
    endcase
  end

  assign oSEL  = sel_q;
  assign oMASK = mask_q;
  assign oE    = e_q;
  assign oRST  = (state_q == S_LOAD);
  assign oACK  = (state_q == S_DONE) && !init_q;
  assign oBUSY = (state_q != S_IDLE);

`ifdef SKIP_CTL_TIMEOUT_EN
  assign oERR = err_q;
`else
  assign oERR = 1'b0;
`endif

endmodule

// File: tb/tb_skip_ctl.sv
module tb_skip_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] sel_in, mask_in;
  logic        en_in;
  logic        ack, busy, err, rst_o, e_o;
  logic [15:0] sel_o, mask_o;
  logic        st;

  // Ring model: applied-enable status is oE delayed by two cycles.
  logic st1 = 1'b0, st2 = 1'b0;
  logic st_stuck = 1'b0;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int rst_hi = 0;

  typedef struct {
    logic [15:0] sel;
    logic [15:0] mask;
    logic        en;
    int          t0;
    int          lat;   // expected latency, 0 = not checked
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  skip_ctl #(
    .LEN    (16),
    .DEFSEL (16'h0001),
    .DEFMASK(16'h0000),
    .DEFE   (1'b0),
    .TMO    (64)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iREQ  (req),
    .iSEL  (sel_in),
    .iMASK (mask_in),
    .iEN   (en_in),
    .oACK  (ack),
    .oBUSY (busy),
    .oERR  (err),
    .oSEL  (sel_o),
    .oMASK (mask_o),
    .oRST  (rst_o),
    .oE    (e_o),
    .iST   (st)
  );

  assign st = st_stuck ? 1'b1 : st2;

  always @(posedge clk) begin
    st1 <= e_o;
    st2 <= st1;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every acknowledge against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("rst_e_excl", {31'b0, rst_o & e_o}, 32'd0);
    if (rst_o === 1'b1) rst_hi++;
    if (ack === 1'b1) begin
      ack_cnt++;
      check("ack_pending", {31'b0, sbq.size() > 0}, 32'd1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("ack_sel", {16'b0, sel_o}, {16'b0, e.sel});
        check("ack_mask", {16'b0, mask_o}, {16'b0, e.mask});
        check("ack_en", {31'b0, e_o}, {31'b0, e.en});
        if (e.lat > 0) check("ack_latency", cyc - e.t0 + 1, e.lat);
      end
    end
  end

  task automatic start_req(input logic [15:0] s, input logic [15:0] m, input logic en,
                           input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    sel_in  = s;
    mask_in = m;
    en_in   = en;
    req     = 1'b1;
    if (push) begin
      e.sel  = (s == 16'h0) ? 16'h1 : s;
      e.mask = m;
      e.en   = en;
      e.t0   = cyc;
      e.lat  = lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    req     = 1'b0;
    sel_in  = 16'($urandom);
    mask_in = 16'($urandom);
    en_in   = 1'($urandom);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < budget);
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int ack_base;
    int n;
    rst_n   = 1'b0;
    req     = 1'b0;
    sel_in  = 16'h0;
    mask_in = 16'h0;
    en_in   = 1'b0;

    // 1: reset, then the unacknowledged INIT pass.
    repeat (3) @(negedge clk);
    check("rst_oE", {31'b0, e_o}, 32'd0);
    check("rst_oRST", {31'b0, rst_o}, 32'd0);
    check("rst_oACK", {31'b0, ack}, 32'd0);
    check("rst_oERR", {31'b0, err}, 32'd0);
    check("rst_oBUSY", {31'b0, busy}, 32'd1);
    check("rst_oSEL", {16'b0, sel_o}, 32'h1);
    check("rst_oMASK", {16'b0, mask_o}, 32'h0);
    rst_hi   = 0;
    ack_base = ack_cnt;
    rst_n    = 1'b1;
    wait_idle("init_idle", 100);
    check("init_rst_cycles", rst_hi, 2);
    check("init_no_ack", ack_cnt - ack_base, 0);
    check("init_oSEL", {16'b0, sel_o}, 32'h1);
    check("init_oMASK", {16'b0, mask_o}, 32'h0);
    check("init_oE", {31'b0, e_o}, 32'd0);

    // 2: enable request from a drained ring; ARM waits 2 extra cycles for iST.
    rst_hi   = 0;
    ack_base = ack_cnt;
    start_req(16'h0001, 16'h00FF, 1'b1, 8, 1'b1);
    wait_idle("t2_idle", 100);
    check("t2_acks", ack_cnt - ack_base, 1);
    check("t2_rst_cycles", rst_hi, 2);
    check("t2_oMASK", {16'b0, mask_o}, 32'h00FF);
    check("t2_oE", {31'b0, e_o}, 32'd1);

    // 3: a second request pulsed while busy is ignored.
    ack_base = ack_cnt;
    start_req(16'h0003, 16'h00FF, 1'b1, 0, 1'b1);
    repeat (3) @(negedge clk);
    sel_in  = 16'hDEAD;
    mask_in = 16'hFFFF;
    en_in   = 1'b0;
    req     = 1'b1;
    @(negedge clk);
    req     = 1'b0;
    wait_idle("t3_idle", 100);
    repeat (8) @(negedge clk);
    check("t3_acks", ack_cnt - ack_base, 1);
    check("t3_oMASK", {16'b0, mask_o}, 32'h00FF);
    check("t3_oSEL", {16'b0, sel_o}, 32'h0003);
    check("t3_idle_after", {31'b0, busy}, 32'd0);

    // 4: zero seed, enable off, ring already drained -> minimum latency.
    start_req(16'h00A5, 16'h1234, 1'b0, 0, 1'b1);
    wait_idle("t4pre_idle", 100);
    ack_base = ack_cnt;
    start_req(16'h0000, 16'h0F0F, 1'b0, 6, 1'b1);
    wait_idle("t4_idle", 100);
    check("t4_acks", ack_cnt - ack_base, 1);
    check("t4_oSEL", {16'b0, sel_o}, 32'h1);
    check("t4_oE", {31'b0, e_o}, 32'd0);

    // 5: reset during LOAD aborts the request and reruns INIT.
    ack_base = ack_cnt;
    start_req(16'h0F00, 16'hAAAA, 1'b1, 0, 1'b0);
    n = 0;
    while (rst_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_load_seen", {31'b0, rst_o}, 32'd1);
    check("t5_load_oSEL", {16'b0, sel_o}, 32'h0F00);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_oSEL", {16'b0, sel_o}, 32'h1);
    check("t5_rst_oMASK", {16'b0, mask_o}, 32'h0);
    check("t5_rst_oRST", {31'b0, rst_o}, 32'd0);
    check("t5_rst_oBUSY", {31'b0, busy}, 32'd1);
    rst_n  = 1'b1;
    rst_hi = 0;
    wait_idle("t5_idle", 100);
    check("t5_no_ack", ack_cnt - ack_base, 0);
    check("t5_rst_cycles", rst_hi, 2);
    check("t5_oSEL", {16'b0, sel_o}, 32'h1);
    check("t5_oMASK", {16'b0, mask_o}, 32'h0);

    // 6: ring status stuck high.
    st_stuck = 1'b1;
    ack_base = ack_cnt;
    start_req(16'h0055, 16'h0F0F, 1'b1, 0, 1'b0);
`ifdef SKIP_CTL_TIMEOUT_EN
    n = 1;
    while (err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_drain_cycles", n - 1, 64);
    check("t6_oE", {31'b0, e_o}, 32'd0);
    check("t6_oBUSY", {31'b0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    check("t6_oERR_sticky", {31'b0, err}, 32'd1);
    check("t6_oBUSY_hold", {31'b0, busy}, 32'd1);
    check("t6_oRST", {31'b0, rst_o}, 32'd0);
`else
    repeat (100) @(negedge clk);
    check("t6_oBUSY", {31'b0, busy}, 32'd1);
    check("t6_oERR", {31'b0, err}, 32'd0);
    check("t6_oE", {31'b0, e_o}, 32'd0);
`endif
    check("t6_no_ack", ack_cnt - ack_base, 0);
    st_stuck = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_oERR", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    wait_idle("t6_idle", 100);
    check("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
